// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
// Holds the request size encodings and the controller FSM state encoding
// so the top level and the alignment datapath agree on them.
package mem_pkg;

  // Access width as carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Controller states: wait for a request, touch data_ram for one cycle,
  // then present the response until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Purely combinational lane alignment for byte/half/word accesses.
// Ports:
//   size        access width (mem_pkg::size_e encoding)
//   is_unsigned loads: 1 = zero-extend, 0 = sign-extend
//   addr_lo     byte offset within the word
//   wdata       right-justified store data
//   rdata       raw word read from data_ram
//   wen         byte enables for a store of this size/offset
//   wdata_align store data replicated onto every candidate lane
//   rdata_ext   selected lane, extended to 32 bits
//   misalign    half on an odd address or word not on a word boundary
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wen,
  output logic [31:0] wdata_align,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half out of the read word (little-endian).
  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lo)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Narrow stores replicate their data across the word so that whichever
  // lane the enables open already holds the right bits. The reserved size
  // produces no enables and no load data; the top level flags it as an error.
  always_comb begin
    wen         = 4'b0000;
    wdata_align = wdata;
    rdata_ext   = 32'h0;
    misalign    = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        wen         = 4'b0001 << addr_lo;
        wdata_align = {4{wdata[7:0]}};
        rdata_ext   = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        wen         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_align = {2{wdata[15:0]}};
        rdata_ext   = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
        misalign    = addr_lo[0];
      end
      SZ_WORD: begin
        wen         = 4'b1111;
        wdata_align = wdata;
        rdata_ext   = rdata;
        misalign    = |addr_lo;
      end
      default: begin
        wen         = 4'b0000;
        wdata_align = wdata;
        rdata_ext   = 32'h0;
        misalign    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller in front of data_ram.
// Accepts one request at a time over req_valid/req_ready, spends exactly one
// cycle driving data_ram, then holds the response on resp_valid/resp_ready.
// Ports:
//   clk, resetn                clock and asynchronous active-low reset
//   req_*                      request channel (op, size, sign, addr, data)
//   resp_valid/ready/rdata/err response channel
//   dm_wen/addr/wdata/rdata    data_ram interface (async read)
//   load_cnt/store_cnt/err_cnt saturating activity counters for the display
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        dm_wen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e      state, next_state;

  logic        op_wr;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  logic [3:0]  align_wen;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        align_misalign;
  logic        op_err;

  mem_align u_align (
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .addr_lo     (op_addr[1:0]),
    .wdata       (op_wdata),
    .rdata       (dm_rdata),
    .wen         (align_wen),
    .wdata_align (align_wdata),
    .rdata_ext   (align_rdata),
    .misalign    (align_misalign)
  );

  // Any address bit above the attached RAM is out of range.
  assign op_err = (op_size == SZ_RSVD) || align_misalign || (|op_addr[31:ADDR_W+2]);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next state. Only IDLE accepts, so a request arriving while RESP is
  // finishing waits for the following IDLE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture on acceptance; the latched fields keep driving dm_addr
  // and dm_wdata until the next request replaces them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_wr       <= 1'b0;
      op_size     <= SZ_BYTE;
      op_unsigned <= 1'b0;
      op_addr     <= 32'h0;
      op_wdata    <= 32'h0;
    end else if (state == IDLE && req_valid) begin
      op_wr       <= req_wr;
      op_size     <= req_size;
      op_unsigned <= req_unsigned;
      op_addr     <= req_addr;
      op_wdata    <= req_wdata;
    end
  end

  // Response capture at the end of ACCESS. Stores and errored requests
  // return zero data. Values are then held for the whole RESP stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_rdata <= (op_wr || op_err) ? 32'h0 : align_rdata;
      resp_err   <= op_err;
    end
  end

  // Counters advance once per request, at the end of its ACCESS cycle,
  // and stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else if (state == ACCESS) begin
      if (op_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (op_wr) begin
        if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
      end else begin
        if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
      end
    end
  end

  // Write enables come straight from the state so an asynchronous reset
  // cuts a store off immediately.
  assign dm_wen     = (state == ACCESS && op_wr && !op_err) ? align_wen : 4'b0000;
  assign dm_addr    = op_addr[ADDR_W+1:2];
  assign dm_wdata   = align_wdata;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural data_ram.
// Counters are built 4 bits wide so saturation can be reached quickly.
module tb_mem_access_unit;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [3:0]        dm_wen;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  store_cnt;
  logic [CNT_W-1:0]  err_cnt;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Values seen during the most recent transaction.
  logic [3:0]        acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_valid;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  mem_access_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_wen       (dm_wen),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_ram: asynchronous read, byte-enabled synchronous write.
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (dm_wen[k]) mem[dm_addr][8*k +: 8] <= dm_wdata[8*k +: 8];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Runs one complete request with resp_ready raised as soon as RESP shows.
  task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid    = 1'b1;
    req_wr       = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_wen   = dm_wen;
    acc_addr  = dm_addr;
    acc_wdata = dm_wdata;
    acc_valid = resp_valid;
    @(posedge clk);
    #1;
    rsp_valid  = resp_valid;
    rsp_rdata  = resp_rdata;
    rsp_err    = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
    resetn       = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;
    #1;
    check_output("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_output("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_output("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check_output("rst_resp_rdata", resp_rdata, 32'h0);
    check_output("rst_dm_wen", {28'h0, dm_wen}, 32'h0);
    check_output("rst_dm_addr", {27'h0, dm_addr}, 32'h0);
    check_output("rst_dm_wdata", dm_wdata, 32'h0);
    check_output("rst_counters", {20'h0, load_cnt, store_cnt, err_cnt}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] SW/LW round trip");
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h89ABCDEF);
    check_output("sw_wen", {28'h0, acc_wen}, 32'hF);
    check_output("sw_addr", {27'h0, acc_addr}, 32'h4);
    check_output("sw_wdata", acc_wdata, 32'h89ABCDEF);
    check_output("sw_valid_in_access", {31'h0, acc_valid}, 32'h0);
    check_output("sw_resp", {rsp_valid, rsp_err}, 2'b10);
    check_output("sw_rdata", rsp_rdata, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_output("lw_wen", {28'h0, acc_wen}, 32'h0);
    check_output("lw_resp", {rsp_valid, rsp_err}, 2'b10);
    check_output("lw_rdata", rsp_rdata, 32'h89ABCDEF);

    $display("[TB] byte store and loads");
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    check_output("sb_wen", {28'h0, acc_wen}, 32'h2);
    check_output("sb_wdata", acc_wdata, 32'h55555555);
    check_output("sb_mem", mem[4], 32'h89AB55EF);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check_output("lb_11", rsp_rdata, 32'h00000055);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check_output("lbu_13", rsp_rdata, 32'h00000089);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check_output("lb_13", rsp_rdata, 32'hFFFFFF89);

    $display("[TB] half loads and store");
    apply_stimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check_output("lh_12", rsp_rdata, 32'hFFFF89AB);
    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check_output("lhu_12", rsp_rdata, 32'h000089AB);
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h06, 32'hAAAA1234);
    check_output("sh_wen", {28'h0, acc_wen}, 32'hC);
    check_output("sh_mem", mem[1], 32'h12340000);

    $display("[TB] error requests");
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFFFFFF);
    check_output("err_sh_wen", {28'h0, acc_wen}, 32'h0);
    check_output("err_sh_resp", {rsp_valid, rsp_err}, 2'b11);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFFFFFF);
    check_output("err_sw_wen", {28'h0, acc_wen}, 32'h0);
    check_output("err_sw_resp", {rsp_valid, rsp_err}, 2'b11);
    apply_stimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF);
    check_output("err_rsvd_wen", {28'h0, acc_wen}, 32'h0);
    check_output("err_rsvd_resp", {rsp_valid, rsp_err}, 2'b11);
    check_output("err_rsvd_rdata", rsp_rdata, 32'h0);
    check_output("err_mem0", mem[0], 32'h0);
    check_output("err_mem8", mem[8], 32'h0);
    check_output("err_mem4", mem[4], 32'h89AB55EF);
    check_output("cnt_err3", {28'h0, err_cnt}, 32'd3);
    check_output("cnt_load6", {28'h0, load_cnt}, 32'd6);
    check_output("cnt_store3", {28'h0, store_cnt}, 32'd3);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    check_output("err_lw_resp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
    check_output("cnt_err4", {28'h0, err_cnt}, 32'd4);

    $display("[TB] response backpressure");
    @(negedge clk);
    req_valid    = 1'b1;
    req_wr       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    @(posedge clk);
    #1;
    req_size     = 2'b00;
    req_unsigned = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_output("bp_hold", {resp_valid, req_ready, resp_err, resp_rdata}, {3'b100, 32'h89AB55EF});
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_output("bp_idle", {req_ready, resp_valid}, 2'b10);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("bp_accepted", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check_output("bp_second", {resp_valid, resp_rdata}, {1'b1, 32'h000000EF});
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;

    $display("[TB] reset during store");
    @(negedge clk);
    req_valid    = 1'b1;
    req_wr       = 1'b1;
    req_size     = 2'b10;
    req_addr     = 32'h18;
    req_wdata    = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("rst_mid_wen_pre", {28'h0, dm_wen}, 32'hF);
    #2;
    resetn = 1'b0;
    #1;
    check_output("rst_mid_wen_cut", {28'h0, dm_wen}, 32'h0);
    @(posedge clk);
    #1;
    check_output("rst_mid_mem", mem[6], 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_output("rst_mid_ready", {req_ready, resp_valid}, 2'b10);
    check_output("rst_mid_counters", {20'h0, load_cnt, store_cnt, err_cnt}, 32'h0);

    $display("[TB] load counter saturation");
    for (int n = 0; n < 15; n++) apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_output("sat_reach", {28'h0, load_cnt}, 32'd15);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_output("sat_hold", {28'h0, load_cnt}, 32'd15);
    check_output("sat_data", rsp_rdata, 32'h89AB55EF);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store access controller sitting directly upstream of data_ram in the memory stage. It accepts one byte/half/word load or store request from the CPU pipeline over a valid/ready handshake. It drives data_ram's word address, byte write enables and lane-aligned write data, then returns sign/zero-extended load data over a valid/ready response channel. It also keeps saturating access counters for the board display.

Parameters:
ADDR_W, 5, word-address width of the attached data_ram (2^ADDR_W words, byte space 2^(ADDR_W+2)).
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_wr  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, out-of-range or reserved-size request.
dm_wen  out  4  byte write enables to data_ram.
dm_addr  out  ADDR_W  word address to data_ram.
dm_wdata  out  32  lane-aligned write data to data_ram.
dm_rdata  in  32  asynchronous read data from data_ram.
load_cnt  out  CNT_W  completed error-free loads.
store_cnt  out  CNT_W  completed error-free stores.
err_cnt  out  CNT_W  errored requests.

Behaviour:
- Clocking: single clock domain on clk. Reset is asynchronous and active-low on resetn.
- Endianness is little-endian. Byte lane k of dm_wdata/dm_rdata is bits [8k+7:8k].
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op, size, unsigned flag, address and wdata, then go to ACCESS.
  - ACCESS: one cycle. Capture the extracted load result into resp_rdata. Go to RESP.
  - RESP: resp_valid=1, outputs held stable. On resp_ready, go to IDLE.
- req_ready is 0 in ACCESS and RESP. Throughput is at most one request per 3 cycles.
- Latency: a request accepted at edge N has ACCESS during cycle N+1. resp_valid rises after edge N+2.
- A req_valid arriving in the same cycle that RESP completes is not accepted until the next IDLE cycle.
- Error conditions (any one sets the error):
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - req_addr[31:ADDR_W+2] nonzero.
- Error response: resp_err=1, resp_rdata=0, and dm_wen stays 0 for the whole transaction.
- dm_addr = latched addr[ADDR_W+1:2], held outside ACCESS as well.
- dm_wen is nonzero only during ACCESS of an error-free store. It is decoded combinationally from the state, so an asynchronous reset forces it to 0 immediately.
- Store byte enables and write data:
  - Byte: wen = 1<<addr[1:0], wdata = {4{b}}.
  - Half: wen = addr[1] ? 1100 : 0011, wdata = {2{h}}.
  - Word: wen = 1111, wdata unchanged.
  - dm_wdata is don't-care when dm_wen=0.
- Loads: select the byte or half lane by addr[1:0]/addr[1]. Extend to 32 bits per req_unsigned. A word load passes through unchanged.
- Counters increment by 1 at the ACCESS edge according to the request's outcome. Each counter saturates at all-ones.
- Reset values:
  - state = IDLE, so req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - dm_wen=0, dm_addr=0, dm_wdata=0.
  - All counters = 0.
- Reset mid-transaction: the transaction is abandoned with no write and no response. A store in ACCESS is cut off asynchronously.

Decomposition:
- Package mem_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - FSM state encoding IDLE/ACCESS/RESP.
- One combinational sub-module, mem_align. It takes size, unsigned flag, addr[1:0], wdata and rdata. It produces wen, aligned wdata, extended rdata and the misalign flag.
- The FSM, latches and counters stay in mem_access_unit.

Test Plan:
1. SW addr 0x10, data 0x89ABCDEF, then LW addr 0x10 -> dm_wen=1111 and dm_addr=4 in the store ACCESS cycle; load resp_rdata=0x89ABCDEF, resp_err=0, resp_valid 2 cycles after acceptance.
2. After test 1: SB addr 0x11, data 0x55, then LB 0x11 and LBU 0x13 -> dm_wen=0010; word reads back 0x89AB55EF; LB returns 0x00000055; LBU returns 0x00000089.
3. LH addr 0x12 signed vs LHU 0x12 with word 0x89AB55EF -> 0xFFFF89AB and 0x000089AB.
4. Errors: SH addr 0x03, SW addr 0x80, size=11 -> resp_err=1 each, dm_wen stays 0000, memory unchanged, err_cnt=3.
5. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout; a pending req_valid is accepted one cycle after the resp handshake.
6. Assert resetn low during a store ACCESS cycle -> dm_wen drops to 0 without waiting for a clock edge; target word unchanged; after release req_ready=1 and counters=0. Separately, force load_cnt to all-ones, issue one more load -> count holds at all-ones.
